// File: rtl/rsa_pkg.sv
// Shared definitions for the modular-exponentiation engine: FSM encodings,
// default operand width and the cycle-latency formula.
package rsa_pkg;

  localparam int WIDTH_DEFAULT = 128;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CHECK    = 4'd1,
    ST_SQ       = 4'd2,
    ST_SQ_WAIT  = 4'd3,
    ST_MUL      = 4'd4,
    ST_MUL_WAIT = 4'd5,
    ST_NEXT     = 4'd6,
    ST_FIN      = 4'd7
  } state_t;

  // Cycles from the accepting edge to the edge at which done is seen high.
  function automatic int mod_exp_latency(input int width, input int nbits, input int pop);
    return 2 + (width + 2) * (nbits + pop);
  endfunction

endpackage

// File: rtl/mod_mul_interleaved.sv
// Interleaved (shift-and-add) modular multiplier: p = a*b mod n, one bit of a
// per cycle, MSB first. Requires a, b < n. done pulses WIDTH+1 cycles after go.
module mod_mul_interleaved #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] a_sh, b_r, n_r, r, addend, r_next;
  logic [WIDTH+1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic             run;

  // 2R + B < 3n, so two conditional subtracts bring the step back below n.
  function automatic logic [WIDTH-1:0] reduce2(input logic [WIDTH+1:0] x,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH+1:0] t;
    t = (x >= {2'b00, m}) ? x - {2'b00, m} : x;
    t = (t >= {2'b00, m}) ? t - {2'b00, m} : t;
    return t[WIDTH-1:0];
  endfunction

  assign addend = a_sh[WIDTH-1] ? b_r : '0;
  assign sum    = {1'b0, r, 1'b0} + {2'b00, addend};
  assign r_next = reduce2(sum, n_r);
  assign p      = r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run  <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      r    <= '0;
    end else begin
      done <= 1'b0;
      if (go) begin
        run <= 1'b1;
        cnt <= CNT_W'(WIDTH - 1);
        r   <= '0;
      end else if (run) begin
        r <= r_next;
        if (cnt == '0) begin
          run  <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (go) begin
      a_sh <= a;
      b_r  <= b;
      n_r  <= n;
    end else if (run) begin
      a_sh <= a_sh << 1;
    end
  end

endmodule

// File: rtl/mod_exp_engine.sv
// Left-to-right square-and-multiply modular exponentiation over one shared
// interleaved multiplier. Option macro: MOD_EXP_SKIP_LEADING_ZEROS_EN.
module mod_exp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic [WIDTH-1:0]     result,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int               IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     base_q, mod_q, acc_q, mm_b, mm_p, fin_result;
  logic [EXP_WIDTH-1:0] exp_q, exp_aligned;
  logic [IDX_W-1:0]     idx_q, start_idx;
  logic                 accept, chk_err, skip_done, fin_entry, mm_go, mm_done;

  assign accept  = start && (state_q == ST_IDLE || state_q == ST_FIN);
  assign chk_err = (mod_q[WIDTH-1:1] == '0) || (base_q >= mod_q);

`ifdef MOD_EXP_SKIP_LEADING_ZEROS_EN
  logic [IDX_W-1:0] msb_idx;

  always_comb begin
    msb_idx = '0;
    for (int i = 0; i < EXP_WIDTH; i++) begin
      if (exp_q[i]) msb_idx = IDX_W'(i);
    end
  end

  // Align the leading one to the top so the scan always reads the MSB.
  assign start_idx   = msb_idx;
  assign exp_aligned = exp_q << (IDX_W'(EXP_WIDTH - 1) - msb_idx);
  assign skip_done   = (exp_q == '0);
`else
  assign start_idx   = IDX_W'(EXP_WIDTH - 1);
  assign exp_aligned = exp_q;
  assign skip_done   = 1'b0;
`endif

  // NEXT issues the following square itself so every operation costs WIDTH+2 cycles.
  always_comb begin
    state_d = state_q;
    mm_go   = 1'b0;
    mm_b    = acc_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = ST_CHECK;
      ST_CHECK:    state_d = (chk_err || skip_done) ? ST_FIN : ST_SQ;
      ST_SQ: begin
        mm_go   = 1'b1;
        state_d = ST_SQ_WAIT;
      end
      ST_SQ_WAIT: begin
        if (mm_done) begin
          if (exp_q[EXP_WIDTH-1]) state_d = ST_MUL;
          else if (idx_q == '0)   state_d = ST_FIN;
          else                    state_d = ST_NEXT;
        end
      end
      ST_MUL: begin
        mm_go   = 1'b1;
        mm_b    = base_q;
        state_d = ST_MUL_WAIT;
      end
      ST_MUL_WAIT: if (mm_done) state_d = (idx_q == '0) ? ST_FIN : ST_NEXT;
      ST_NEXT: begin
        mm_go   = 1'b1;
        state_d = ST_SQ_WAIT;
      end
      ST_FIN:      state_d = accept ? ST_CHECK : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign fin_entry  = (state_d == ST_FIN);
  assign fin_result = (state_q == ST_CHECK) ? (chk_err ? '0 : ONE) : mm_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= fin_entry;
      if (accept)         busy <= 1'b1;
      else if (fin_entry) busy <= 1'b0;
      if (fin_entry) begin
        result <= fin_result;
        err    <= (state_q == ST_CHECK) && chk_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      base_q <= base;
      exp_q  <= exponent;
      mod_q  <= modulus;
    end
    case (state_q)
      ST_CHECK: begin
        acc_q <= ONE;
        idx_q <= start_idx;
        exp_q <= exp_aligned;
      end
      ST_SQ_WAIT, ST_MUL_WAIT: if (mm_done) acc_q <= mm_p;
      ST_NEXT: begin
        idx_q <= idx_q - IDX_W'(1);
        exp_q <= exp_q << 1;
      end
      default: ;
    endcase
  end

  mod_mul_interleaved #(.WIDTH(WIDTH)) u_mm (
    .clk     (clk),
    .reset_n (reset_n),
    .go      (mm_go),
    .a       (acc_q),
    .b       (mm_b),
    .n       (mod_q),
    .p       (mm_p),
    .done    (mm_done)
  );

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed bench for mod_exp_engine at WIDTH=8, 128 and 16 with a small
// software reference for the 16-bit sweep.
module tb_mod_exp_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic s8, bz8, dn8, er8;
  logic [7:0] b8, e8, m8, r8;
  logic s128, bz128, dn128, er128;
  logic [127:0] b128, e128, m128, r128;
  logic s16, bz16, dn16, er16;
  logic [15:0] b16, e16, m16, r16;

  int total = 0;
  int bad   = 0;

  mod_exp_engine #(.WIDTH(8), .EXP_WIDTH(8)) u_w8 (
    .clk(clk), .reset_n(reset_n), .start(s8), .base(b8), .exponent(e8), .modulus(m8),
    .result(r8), .busy(bz8), .done(dn8), .err(er8));
  mod_exp_engine #(.WIDTH(128)) u_w128 (
    .clk(clk), .reset_n(reset_n), .start(s128), .base(b128), .exponent(e128), .modulus(m128),
    .result(r128), .busy(bz128), .done(dn128), .err(er128));
  mod_exp_engine #(.WIDTH(16), .EXP_WIDTH(16)) u_w16 (
    .clk(clk), .reset_n(reset_n), .start(s16), .base(b16), .exponent(e16), .modulus(m16),
    .result(r16), .busy(bz16), .done(dn16), .err(er16));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int exp_lat(input int w, input int ew, input logic [127:0] e);
    int nb = 0;
    int pc = 0;
    for (int i = 0; i < ew; i++) if (e[i]) begin pc++; nb = i + 1; end
`ifndef MOD_EXP_SKIP_LEADING_ZEROS_EN
    nb = ew;
`endif
    return 2 + (w + 2) * (nb + pc);
  endfunction

  function automatic longint unsigned ref_modexp(input longint unsigned b, input logic [15:0] e,
                                                 input longint unsigned n);
    longint unsigned r = 1;
    for (int i = 15; i >= 0; i--) begin
      r = (r * r) % n;
      if (e[i]) r = (r * b) % n;
    end
    return r;
  endfunction

  task automatic drive(input int sel, input logic st, input logic [127:0] b, e, m);
    case (sel)
      8:       begin s8 = st;   b8 = b[7:0];   e8 = e[7:0];   m8 = m[7:0];   end
      16:      begin s16 = st;  b16 = b[15:0]; e16 = e[15:0]; m16 = m[15:0]; end
      default: begin s128 = st; b128 = b;      e128 = e;      m128 = m;      end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      8:       return dn8;
      16:      return dn16;
      default: return dn128;
    endcase
  endfunction

  function automatic logic [127:0] get_res(input int sel);
    case (sel)
      8:       return {120'd0, r8};
      16:      return {112'd0, r16};
      default: return r128;
    endcase
  endfunction

  function automatic logic get_err(input int sel);
    case (sel)
      8:       return er8;
      16:      return er16;
      default: return er128;
    endcase
  endfunction

  // lat = number of edges from the accepting edge to the edge that sees done high.
  task automatic run_op(input int sel, input logic [127:0] b, e, m,
                        output logic [127:0] res, output logic er, output int lat);
    @(negedge clk);
    drive(sel, 1'b1, b, e, m);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) drive(sel, 1'b0, b, e, m);
    end while (!get_done(sel) && lat < 40000);
    chk("done_within_budget", {127'd0, get_done(sel)}, 128'd1);
    res = get_res(sel);
    er  = get_err(sel);
  endtask

  logic [127:0] res;
  logic         er;
  int           lat;
  int           ndone;
  logic [15:0]  rb, re, rm;

  initial begin
    reset_n = 1'b1;
    drive(8, 1'b0, 0, 0, 0);
    drive(16, 1'b0, 0, 0, 0);
    drive(128, 1'b0, 0, 0, 0);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_result", {120'd0, r8}, 128'd0);
    chk("reset_busy", {127'd0, bz8}, 128'd0);
    chk("reset_done", {127'd0, dn8}, 128'd0);
    chk("reset_err", {127'd0, er8}, 128'd0);
    chk("reset_busy128", {127'd0, bz128}, 128'd0);
    reset_n = 1'b1;

    run_op(8, 5, 3, 33, res, er, lat);
    chk("w8_5^3%33", res, 128'd26);
    chk("w8_5^3%33_err", {127'd0, er}, 128'd0);
    chk("w8_5^3%33_lat", lat, exp_lat(8, 8, 3));
    @(negedge clk);
    chk("done_is_pulse", {127'd0, dn8}, 128'd0);
    chk("busy_after_done", {127'd0, bz8}, 128'd0);
    chk("result_held", {120'd0, r8}, 128'd26);

    run_op(128, 65, 17, 3233, res, er, lat);
    chk("w128_encrypt", res, 128'd2790);
    chk("w128_encrypt_err", {127'd0, er}, 128'd0);
    chk("w128_encrypt_lat", lat, exp_lat(128, 128, 17));
    run_op(128, 2790, 2753, 3233, res, er, lat);
    chk("w128_decrypt", res, 128'd65);
    chk("w128_decrypt_lat", lat, exp_lat(128, 128, 2753));

    run_op(8, 0, 3, 1, res, er, lat);
    chk("n1_err", {127'd0, er}, 128'd1);
    chk("n1_result", res, 128'd0);
    chk("n1_lat", lat, 2);
    run_op(8, 40, 3, 33, res, er, lat);
    chk("base_ge_n_err", {127'd0, er}, 128'd1);
    chk("base_ge_n_result", res, 128'd0);
    run_op(8, 7, 0, 33, res, er, lat);
    chk("exp0_result", res, 128'd1);
    chk("exp0_err", {127'd0, er}, 128'd0);
    chk("exp0_lat", lat, exp_lat(8, 8, 0));
    run_op(8, 0, 5, 33, res, er, lat);
    chk("base0_result", res, 128'd0);
    run_op(8, 2, 7, 255, res, er, lat);
    chk("w8_2^7%255", res, 128'd128);
    chk("w8_2^7%255_lat", lat, exp_lat(8, 8, 7));

    // Keep start high with different operands while busy; only the first counts.
    @(negedge clk);
    drive(8, 1'b1, 5, 3, 33);
    ndone = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (dn8) begin
        ndone++;
        drive(8, 1'b0, 7, 5, 11);
      end else if (ndone == 0) begin
        drive(8, 1'b1, 7, 5, 11);
      end
    end
    chk("repulse_done_count", ndone, 1);
    chk("repulse_result", {120'd0, r8}, 128'd26);

    // Abort mid-square: reset must clear outputs immediately.
    @(negedge clk);
    drive(8, 1'b1, 2, 7, 255);
    @(negedge clk);
    drive(8, 1'b0, 2, 7, 255);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_result", {120'd0, r8}, 128'd0);
    chk("abort_busy", {127'd0, bz8}, 128'd0);
    chk("abort_done", {127'd0, dn8}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(8, 5, 3, 33, res, er, lat);
    chk("after_abort_result", res, 128'd26);
    chk("after_abort_lat", lat, exp_lat(8, 8, 3));

    for (int t = 0; t < 12; t++) begin
      rm = 16'($urandom_range(65535, 2));
      rb = 16'($urandom % {16'd0, rm});
      re = 16'($urandom_range(65535, 0));
      run_op(16, {112'd0, rb}, {112'd0, re}, {112'd0, rm}, res, er, lat);
      chk("sweep_result", res, 128'(ref_modexp(64'(rb), re, 64'(rm))));
      chk("sweep_err", {127'd0, er}, 128'd0);
      chk("sweep_lat", lat, exp_lat(16, 16, {112'd0, re}));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
